// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants for the PS/2 key decoder slice: prefix and control scan
// codes, the mapped make codes, key-code constants and the FSM state type.
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;

  // Keyboard control / status bytes (never part of a key sequence)
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_ECHO     = 8'hEE;
  localparam logic [7:0] SC_ERR_LO   = 8'h00;
  localparam logic [7:0] SC_ERR_HI   = 8'hFF;

  // Player 1: W S A D
  localparam logic [7:0] SC_W        = 8'h1D;
  localparam logic [7:0] SC_S        = 8'h1B;
  localparam logic [7:0] SC_A        = 8'h1C;
  localparam logic [7:0] SC_D        = 8'h23;
  // Player 2: arrows (only valid after E0)
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  // Player 3: I K J L
  localparam logic [7:0] SC_I        = 8'h43;
  localparam logic [7:0] SC_K        = 8'h42;
  localparam logic [7:0] SC_J        = 8'h3B;
  localparam logic [7:0] SC_L        = 8'h4B;
  // Player 4: keypad 8 5 4 6 (same bytes as the arrows, but without E0)
  localparam logic [7:0] SC_KP8      = 8'h75;
  localparam logic [7:0] SC_KP5      = 8'h73;
  localparam logic [7:0] SC_KP4      = 8'h6B;
  localparam logic [7:0] SC_KP6      = 8'h74;
  // Game start
  localparam logic [7:0] SC_SPACE    = 8'h29;

  localparam logic [4:0] KEY_IDLE    = 5'd31;
  localparam logic [4:0] KEY_START   = 5'd16;
  localparam int         NUM_KEYS    = 17;

  // Number of bytes that follow E1 in the Pause make sequence
  localparam logic [2:0] PAUSE_TAIL  = 3'd7;

  // Decoder FSM states
  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE       = 3'd0;
  localparam fsm_state_t ST_EXT        = 3'd1;
  localparam fsm_state_t ST_BRK        = 3'd2;
  localparam fsm_state_t ST_EXT_BRK    = 3'd3;
  localparam fsm_state_t ST_PAUSE_SKIP = 3'd4;

  // True for keyboard status bytes that abort any partial sequence
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic r;
    case (b)
      SC_BAT_OK, SC_ACK, SC_RESEND, SC_ECHO, SC_ERR_LO, SC_ERR_HI: r = 1'b1;
      default:                                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// ---------------------------------------------------------------------------
// ps2_scancode_lut
// Combinational lookup from {extended flag, scan byte} to a key code.
// Ports:
//   ext        in  1  byte was preceded by E0
//   scan_byte  in  8  make/break code byte
//   hit        out 1  byte maps to a game key
//   code       out 5  key code 0..16 when hit, KEY_IDLE otherwise
// ---------------------------------------------------------------------------
module ps2_scancode_lut
  import ps2_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] scan_byte,
  output logic       hit,
  output logic [4:0] code
);

  // Map table; within each player the order is up, down, left, right
  always_comb begin
    hit  = 1'b1;
    code = KEY_IDLE;
    case ({ext, scan_byte})
      {1'b0, SC_W}:     code = 5'd0;
      {1'b0, SC_S}:     code = 5'd1;
      {1'b0, SC_A}:     code = 5'd2;
      {1'b0, SC_D}:     code = 5'd3;
      {1'b1, SC_UP}:    code = 5'd4;
      {1'b1, SC_DOWN}:  code = 5'd5;
      {1'b1, SC_LEFT}:  code = 5'd6;
      {1'b1, SC_RIGHT}: code = 5'd7;
      {1'b0, SC_I}:     code = 5'd8;
      {1'b0, SC_K}:     code = 5'd9;
      {1'b0, SC_J}:     code = 5'd10;
      {1'b0, SC_L}:     code = 5'd11;
      {1'b0, SC_KP8}:   code = 5'd12;
      {1'b0, SC_KP5}:   code = 5'd13;
      {1'b0, SC_KP4}:   code = 5'd14;
      {1'b0, SC_KP6}:   code = 5'd15;
      {1'b0, SC_SPACE}: code = KEY_START;
      default: begin
        hit  = 1'b0;
        code = KEY_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns the PS/2 scan-code byte stream into one-cycle key-code pulses for the
// directions stage, a game-start strobe and a held-key bitmap. Handles E0/F0
// prefixes, typematic repeat suppression, the 8-byte Pause sequence and a
// timeout that drops a dangling prefix.
// Ports:
//   CLOCK_50        in   1  50 MHz system clock
//   reset           in   1  synchronous, active-high
//   ps2_byte        in   8  received scan-code byte
//   ps2_byte_valid  in   1  one-cycle strobe qualifying ps2_byte
//   KEY_PRESSED     out  5  key code for one cycle on a make, else 31
//   key_valid       out  1  KEY_PRESSED carries a code 0..16
//   start_pulse     out  1  one-cycle pulse on a Space make
//   key_held        out 17  bitmap of held mapped keys, bit n = code n
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          ps2_byte,
  input  logic                ps2_byte_valid,
  output logic [4:0]          KEY_PRESSED,
  output logic                key_valid,
  output logic                start_pulse,
  output logic [NUM_KEYS-1:0] key_held
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  fsm_state_t    state_r;
  fsm_state_t    state_nxt_s;
  logic [TW-1:0] tmo_cnt_r;
  logic [2:0]    pause_cnt_r;
  logic          in_prefix_s;
  logic          tmo_hit_s;
  logic          is_make_s;
  logic          is_break_s;
  logic          pause_load_s;
  logic          lut_ext_s;
  logic          lut_hit_s;
  logic [4:0]    lut_code_s;

  assign in_prefix_s = (state_r == ST_EXT) || (state_r == ST_BRK) ||
                       (state_r == ST_EXT_BRK);
  assign tmo_hit_s   = in_prefix_s && (tmo_cnt_r == TMO_LAST);
  assign lut_ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);

  ps2_scancode_lut u_lut (
    .ext       (lut_ext_s),
    .scan_byte (ps2_byte),
    .hit       (lut_hit_s),
    .code      (lut_code_s)
  );

  // Next-state decode and classification of the current byte as make/break
  always_comb begin
    state_nxt_s  = state_r;
    is_make_s    = 1'b0;
    is_break_s   = 1'b0;
    pause_load_s = 1'b0;
    if (ps2_byte_valid) begin
      if (state_r == ST_PAUSE_SKIP) begin
        // Pause tail bytes are consumed blindly, control bytes included
        if (pause_cnt_r <= 3'd1) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PAUSE_SKIP;
        end
      end else if (is_ctrl_byte(ps2_byte)) begin
        state_nxt_s = ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (ps2_byte == SC_EXT) begin
              state_nxt_s = ST_EXT;
            end else if (ps2_byte == SC_BRK) begin
              state_nxt_s = ST_BRK;
            end else if (ps2_byte == SC_PAUSE) begin
              state_nxt_s  = ST_PAUSE_SKIP;
              pause_load_s = 1'b1;
            end else begin
              is_make_s   = 1'b1;
              state_nxt_s = ST_IDLE;
            end
          end
          ST_EXT: begin
            if (ps2_byte == SC_BRK) begin
              state_nxt_s = ST_EXT_BRK;
            end else begin
              is_make_s   = 1'b1;
              state_nxt_s = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            is_break_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end
          default: state_nxt_s = ST_IDLE;
        endcase
      end
    end else if (tmo_hit_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prefix timeout counter: idle-gap length while a prefix is pending
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (ps2_byte_valid || !in_prefix_s || tmo_hit_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end

  // Pause tail counter: loaded on E1, counts down one per skipped byte
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pause_cnt_r <= 3'd0;
    end else if (pause_load_s) begin
      pause_cnt_r <= PAUSE_TAIL;
    end else if (ps2_byte_valid && (state_r == ST_PAUSE_SKIP)) begin
      pause_cnt_r <= pause_cnt_r - 3'd1;
    end else begin
      pause_cnt_r <= pause_cnt_r;
    end
  end

  // Registered key outputs and held-key bitmap
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      KEY_PRESSED <= KEY_IDLE;
      key_valid   <= 1'b0;
      start_pulse <= 1'b0;
      key_held    <= '0;
    end else begin
      KEY_PRESSED <= KEY_IDLE;
      key_valid   <= 1'b0;
      start_pulse <= 1'b0;
      if (is_make_s && lut_hit_s) begin
        key_held[lut_code_s] <= 1'b1;
        // A typematic repeat arrives while the key is already held
        if (!key_held[lut_code_s] || REPEAT_EN) begin
          KEY_PRESSED <= lut_code_s;
          key_valid   <= 1'b1;
          start_pulse <= (lut_code_s == KEY_START);
        end
      end else if (is_break_s && lut_hit_s) begin
        key_held[lut_code_s] <= 1'b0;
      end else begin
        key_held <= key_held;
      end
    end
  end

endmodule
